// File: rtl/alsu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2-stage registered ALSU between two requesters.
// Latency: accept to rsp_valid is rep+4 cycles (rep+5 with shift/rotate seed, 4 on error).
// Backpressure: one command in flight; a response is held until rsp_ready.
module alsu_arbiter #(
   parameter int REP_W = 3,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [16+REP_W-1:0] req_cmd0,
   input  logic [16+REP_W-1:0] req_cmd1,
   output logic [2:0]          alsu_A,
   output logic [2:0]          alsu_B,
   output logic [2:0]          alsu_opcode,
   output logic                alsu_cin,
   output logic                alsu_direction,
   output logic                alsu_serial_in,
   output logic                alsu_red_op_A,
   output logic                alsu_red_op_B,
   output logic                alsu_bypass_A,
   output logic                alsu_bypass_B,
   input  logic [5:0]          alsu_out,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [5:0]          rsp_out,
   output logic                rsp_err,
   output logic [CNT_W-1:0]    done_cnt
);

   typedef struct packed {
      logic       bypass_b;
      logic       bypass_a;
      logic       red_op_b;
      logic       red_op_a;
      logic       serial_in;
      logic       direction;
      logic       cin;
      logic [2:0] opcode;
      logic [2:0] b;
      logic [2:0] a;
   } op_t;

   typedef struct packed {
      logic [REP_W-1:0] rep;
      op_t              op;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, SEED, EXEC, DRAIN1, DRAIN2, RESP} state_t;

   state_t           state, nxt;
   logic             ptr;
   op_t              cmd_q;
   logic             id_q;
   logic             err_q;
   logic [REP_W-1:0] cnt;
   op_t              drv;

   cmd_t gnt_cmd;
   logic gnt_any, gnt_id, new_err, is_shift;

   // Pointer only matters when both ports request together.
   assign gnt_any  = |req_valid;
   assign gnt_id   = (req_valid == 2'b11) ? ptr : req_valid[1];
   assign gnt_cmd  = gnt_id ? cmd_t'(req_cmd1) : cmd_t'(req_cmd0);
   assign new_err  = ((gnt_cmd.op.red_op_a | gnt_cmd.op.red_op_b) &
                      (gnt_cmd.op.opcode[1] | gnt_cmd.op.opcode[2])) |
                     (gnt_cmd.op.opcode[1] & gnt_cmd.op.opcode[2]);
   assign is_shift = (gnt_cmd.op.opcode == 3'd4) || (gnt_cmd.op.opcode == 3'd5);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (gnt_any) nxt = (!new_err && is_shift) ? SEED : EXEC;
         SEED:    nxt = EXEC;
         EXEC:    if (cnt == '0) nxt = DRAIN1;
         DRAIN1:  nxt = DRAIN2;
         DRAIN2:  nxt = RESP;
         RESP:    if (rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      drv       = '0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: if (gnt_any) req_ready = gnt_id ? 2'b10 : 2'b01;
         SEED: begin
            // Load A into the ALSU output register so shifts start from it.
            drv.a        = cmd_q.a;
            drv.bypass_a = 1'b1;
         end
         EXEC:    drv = cmd_q;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
      if (reset) begin
         req_ready = 2'b00;
         drv       = '0;
         rsp_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= 1'b0;
         cmd_q    <= '0;
         id_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
         rsp_out  <= '0;
         done_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               cmd_q <= gnt_cmd.op;
               id_q  <= gnt_id;
               err_q <= new_err;
               ptr   <= ~gnt_id;
               cnt   <= new_err ? '0 : gnt_cmd.rep;
            end
            EXEC:    if (cnt != '0) cnt <= cnt - REP_W'(1);
            // Two ALSU register stages: the last EXEC result is visible now.
            DRAIN2:  rsp_out <= alsu_out;
            RESP:    if (rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign rsp_id         = id_q;
   assign rsp_err        = err_q;
   assign alsu_A         = drv.a;
   assign alsu_B         = drv.b;
   assign alsu_opcode    = drv.opcode;
   assign alsu_cin       = drv.cin;
   assign alsu_direction = drv.direction;
   assign alsu_serial_in = drv.serial_in;
   assign alsu_red_op_A  = drv.red_op_a;
   assign alsu_red_op_B  = drv.red_op_b;
   assign alsu_bypass_A  = drv.bypass_a;
   assign alsu_bypass_B  = drv.bypass_b;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: behavioural 2-stage ALSU, directed stimulus, queue scoreboard.
module tb_alsu_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready;
   logic [18:0] req_cmd0, req_cmd1;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_direction, alsu_serial_in;
   logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
   logic [5:0]  alsu_out;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [5:0]  rsp_out;
   logic [15:0] done_cnt;

   alsu_arbiter #(.REP_W(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
      .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
      .alsu_cin(alsu_cin), .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in),
      .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
      .alsu_out(alsu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Behavioural ALSU: inputs registered, then output registered.
   logic [15:0] drv_w, in_r;
   logic [5:0]  out_r;
   assign drv_w = {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                   alsu_serial_in, alsu_direction, alsu_cin, alsu_opcode, alsu_B, alsu_A};
   assign alsu_out = out_r;

   function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] o);
      logic [2:0] a, b, op;
      logic cin, dir, sin, ra, rb, ba, bb;
      a = c[2:0]; b = c[5:3]; op = c[8:6]; cin = c[9]; dir = c[10]; sin = c[11];
      ra = c[12]; rb = c[13]; ba = c[14]; bb = c[15];
      if (((ra | rb) & (op[1] | op[2])) | (op[1] & op[2])) return 6'd0;
      if (ba) return {3'b000, a};
      if (bb) return {3'b000, b};
      case (op)
         3'd0: return ra ? {5'd0, |a} : rb ? {5'd0, |b} : {3'd0, a | b};
         3'd1: return ra ? {5'd0, ^a} : rb ? {5'd0, ^b} : {3'd0, a ^ b};
         3'd2: return {3'd0, a} + {3'd0, b} + {5'd0, cin};
         3'd3: return {3'd0, a} * {3'd0, b};
         3'd4: return dir ? {o[4:0], sin} : {sin, o[5:1]};
         3'd5: return dir ? {o[4:0], o[5]} : {o[0], o[5:1]};
         default: return 6'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         in_r  <= '0;
         out_r <= '0;
      end else begin
         in_r  <= drv_w;
         out_r <= alsu_f(in_r, out_r);
      end
   end

   typedef struct {
      logic       id;
      logic [5:0] out;
      logic       err;
      int         lat;
   } exp_t;
   exp_t exp_q[$];
   int   acc_q[$];

   // Monitor / scoreboard
   logic       prev_v = 1'b0;
   logic [5:0] held_out;
   logic       held_id, held_err;
   int         exp_done = 0;
   bit         chk_done = 1'b0;
   exp_t       mon_e;

   always @(negedge clk) begin
      if (reset) begin
         acc_q.delete();
         exp_done = 0;
         prev_v   = 1'b0;
         chk_done = 1'b0;
      end else begin
         if (chk_done) begin
            check("done_cnt", done_cnt, exp_done);
            chk_done = 1'b0;
         end
         if (req_ready != 2'b00) begin
            check("req_ready_onehot", $onehot(req_ready), 1);
            if (|(req_ready & req_valid)) acc_q.push_back(cyc);
         end
         if (rsp_valid) begin
            check("req_ready_in_resp", req_ready, 0);
            if (!prev_v) begin
               held_out = rsp_out;
               held_id  = rsp_id;
               held_err = rsp_err;
               if (exp_q.size() == 0)      fail_now("unexpected_rsp");
               else if (acc_q.size() == 0) fail_now("rsp_without_accept");
               else check("latency", cyc - acc_q.pop_front(), exp_q[0].lat);
            end else begin
               check("hold_out", rsp_out, held_out);
               check("hold_id", rsp_id, held_id);
               check("hold_err", rsp_err, held_err);
            end
            if (rsp_ready) begin
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("rsp_id", rsp_id, mon_e.id);
                  check("rsp_out", rsp_out, mon_e.out);
                  check("rsp_err", rsp_err, mon_e.err);
               end
               exp_done++;
               chk_done = 1'b1;
            end
         end
         prev_v = rsp_valid && !rsp_ready;
      end
   end

   function automatic logic [18:0] mk(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] op, input logic cin,
                                      input logic dir, input logic sin,
                                      input logic [2:0] rep);
      return {rep, 4'b0000, sin, dir, cin, op, b, a};
   endfunction

   task automatic wait_grant(input logic [1:0] mask);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (|(req_ready & mask)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("grant_timeout");
   endtask

   task automatic send(input logic port, input logic [18:0] cmd, input logic [5:0] eo,
                       input logic ee, input int lat);
      exp_q.push_back('{port, eo, ee, lat});
      if (port) req_cmd1 = cmd;
      else      req_cmd0 = cmd;
      req_valid[port] = 1'b1;
      wait_grant(port ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req_valid[port] = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("drain_timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      int g;
      bit seen;
      reset = 1'b1; req_valid = 2'b00; req_cmd0 = '0; req_cmd1 = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_out", rsp_out, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_done_cnt", done_cnt, 0);
      check("reset_alsu_drive", drv_w, 0);
      check("reset_req_ready", req_ready, 0);

      // Fairness: both ports held valid, expect 0,1,0,1
      @(posedge clk); #1;
      req_cmd0 = mk(3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
      req_cmd1 = mk(3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
      exp_q.push_back('{1'b0, 6'd9, 1'b0, 4});
      exp_q.push_back('{1'b1, 6'd49, 1'b0, 4});
      exp_q.push_back('{1'b0, 6'd9, 1'b0, 4});
      exp_q.push_back('{1'b1, 6'd49, 1'b0, 4});
      req_valid = 2'b11;
      g = 0;
      for (int i = 0; i < 200 && g < 4; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) g++;
      end
      if (g < 4) fail_now("fairness_grant_timeout");
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      // Shift left seeded with A=101, three EXEC cycles
      send(1'b1, mk(3'b101, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 3'd2), 6'd47, 1'b0, 7);
      send(1'b0, mk(3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0), 6'd9, 1'b0, 4);
      send(1'b0, mk(3'b001, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0), 6'd32, 1'b0, 5);
      drain();

      // Invalid opcode with backpressure
      rsp_ready = 1'b0;
      send(1'b1, mk(3'd2, 3'd3, 3'd6, 1'b0, 1'b0, 1'b0, 3'd5), 6'd0, 1'b1, 4);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("invalid_rsp_timeout");
      @(posedge clk); #1;
      req_valid = 2'b11;
      repeat (4) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      drain();

      // Reset while a long command is executing
      req_cmd0 = mk(3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 3'd7);
      req_valid = 2'b01;
      wait_grant(2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("exec_drive", drv_w, 16'h0000 | {4'b0000, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 3'd3});
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alsu_drive", drv_w, 0);
      check("rst_done_cnt", done_cnt, 0);

      @(posedge clk); #1;
      req_cmd0 = mk(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0);
      req_cmd1 = mk(3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
      exp_q.push_back('{1'b0, 6'd2, 1'b0, 4});
      req_valid = 2'b11;
      wait_grant(2'b11);
      check("rst_ptr_grant", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();
      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
endmodule

// File: doc/alsu_arbiter.md
# alsu_arbiter

Two-port round-robin arbiter and sequencer that shares a single ALSU instance between two command requesters. It accepts one command at a time over a valid/ready handshake and drives the ALSU input bus for the required number of cycles. For shift and rotate commands it first issues a seed cycle. It then captures the registered ALSU result at the correct cycle and returns it to the requester that issued the command, tagged with that requester's ID and an error flag.

## Interface
- REP_W, 3: width of the repeat field; a command executes rep+1 cycles.
- CNT_W, 16: width of the completed-command counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port accept strobe; at most one bit high, only in IDLE.
- req_cmd0, req_cmd1  in  19 each  command for each port:
  - A [2:0], B [5:3], opcode [8:6]
  - cin [9], direction [10], serial_in [11]
  - red_op_A [12], red_op_B [13], bypass_A [14], bypass_B [15]
  - rep [18:16]
- alsu_A, alsu_B, alsu_opcode  out  3 each  ALSU operand and opcode drive.
- alsu_cin, alsu_direction, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  ALSU control drive.
- alsu_out  in  6  ALSU registered result.
- rsp_valid  out  1  response valid; held until accepted.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  port that issued the command.
- rsp_out  out  6  captured ALSU result.
- rsp_err  out  1  command was invalid for the ALSU.
- done_cnt  out  CNT_W  count of completed responses; wraps.

## Operation
- Idle command: every alsu_* output is 0.
  - It is driven in IDLE, DRAIN1, DRAIN2 and RESP, and at reset.
- States: IDLE, SEED, EXEC, DRAIN1, DRAIN2, RESP.
- IDLE:
  - With any req_valid high, grant one port and assert its req_ready for that cycle.
  - Latch the command, the port ID, and err.
  - err = ((red_op_A | red_op_B) & (opcode[1] | opcode[2])) | (opcode[1] & opcode[2]).
- Arbitration:
  - Round-robin pointer; after reset port 0 has priority.
  - After a grant to port i, port 1-i has priority.
  - If only one port is valid, it is granted regardless of the pointer.
- Next state after a grant:
  - err=1: EXEC with effective rep = 0.
  - opcode 4 or 5 and err=0: SEED.
  - Otherwise: EXEC.
- SEED (1 cycle): drive opcode=0 and bypass_A=1 with the latched A, all other fields 0; ALSU out becomes {3'b000, A}.
- EXEC:
  - Drive the latched command unchanged for rep+1 consecutive cycles, using a down-counter.
  - Each cycle the ALSU sees the command once; shifts and rotates advance once per cycle.
- DRAIN1, then DRAIN2:
  - At the end of DRAIN2, register alsu_out into rsp_out.
  - That value is the result of the last EXEC cycle.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_out and rsp_err stable until rsp_ready.
  - On the handshake, go to IDLE and increment done_cnt.
  - No grant occurs in the same cycle as the handshake.
- Reset (synchronous, any state):
  - Next state IDLE; pointer to port 0.
  - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_err=0, done_cnt=0, req_ready=0, idle command.
  - A command in flight is dropped with no response.

## Timing
- Let a be the accept cycle.
- Non-shift command: EXEC spans a+1 to a+1+rep; rsp_valid first high at a+rep+4.
- Shift or rotate command: SEED at a+1, EXEC spans a+2 to a+2+rep; rsp_valid first high at a+rep+5.
- err=1 command: rsp_valid first high at a+4.
- Throughput: one command in flight at a time; next earliest accept is the cycle after the RESP handshake.
- req_ready is low in every state except IDLE.
- rsp_valid does not depend combinationally on rsp_ready.

## Test plan
- Basic add: port 0 sends opcode 2, A=3, B=5, cin=1, rep=0 → rsp_out=9, rsp_id=0, rsp_err=0, rsp_valid at a+4.
- Fairness: both ports valid continuously after reset, rsp_ready=1 → grant order 0,1,0,1; port 1 sends multiply A=7, B=7 → rsp_out=49.
- Shift left: opcode 4, direction=1, serial_in=1, A=3'b101, rep=2 → out sequence 000101, 001011, 010111, 101111 → rsp_out=47 at a+7.
- Rotate right: opcode 5, direction=0, A=3'b001, rep=0 → rsp_out=32 at a+5.
- Invalid command: opcode 6, rep=5 → exactly one EXEC cycle, rsp_err=1, rsp_out=0, rsp_valid at a+4.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles → response stable, req_ready=0 on both ports.
  - Assert reset during EXEC → next cycle rsp_valid=0, alsu_* all 0, done_cnt=0, port 0 wins the next simultaneous request.
